// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined N-way mux: output-stage state encoding
// and the default datapath/counter widths.
package datapath_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int XFER_CNT_W    = 16;

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant search: first requesting channel at or above the pointer,
// wrapping modulo N. Purely combinational.
module rr_grant #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant_idx,
  output logic          grant_valid
);

  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  always_comb begin
    logic [SW:0] sum;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (SW+1)'(off);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      if (!grant_valid && req[sum[SW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input mux feeding a single valid/ready output register stage, with either
// select-driven or round-robin channel choice, a sticky range error and a
// wrapping transfer counter.
module pipe_mux_n
  import datapath_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter int   N     = 4,
  parameter int   ARB   = 0,
  localparam int  SW    = (N > 2) ? $clog2(N) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N*WIDTH-1:0]    I,
  input  logic [N-1:0]          IVALID,
  output logic [N-1:0]          IREADY,
  input  logic [SW-1:0]         S,
  output logic [WIDTH-1:0]      O,
  output logic                  OVALID,
  input  logic                  OREADY,
  output logic                  ERR,
  output logic [XFER_CNT_W-1:0] XFER_CNT
);

  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  out_state_e            state_q, state_d;
  logic [WIDTH-1:0]      o_q, o_d;
  logic                  err_q, err_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [SW-1:0]         ptr_q, ptr_d;

  logic [SW-1:0]         rr_idx;
  logic                  rr_valid;
  logic [SW-1:0]         grant_idx;
  logic                  grant_valid;
  logic                  sel_oob;
  logic                  load_en;
  logic                  load;
  logic [N-1:0]          ready;
  logic [WIDTH-1:0]      sel_data;

  rr_grant #(
    .N  (N),
    .SW (SW)
  ) u_rr_grant (
    .req         (IVALID),
    .ptr         (ptr_q),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  always_comb begin
    sel_oob = ({1'b0, S} >= N_EXT);
    if (ARB == 1) begin
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      grant_idx   = S;
      grant_valid = !sel_oob;
    end
  end

  // Ready is gated by reset so no channel sees a handshake while held in reset.
  always_comb begin
    load_en  = (state_q == ST_EMPTY) || OREADY;
    ready    = '0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SW'(k)) begin
        ready[k] = grant_valid && load_en && RST_N;
        sel_data = I[k*WIDTH +: WIDTH];
      end
    end
    load = |(ready & IVALID);
  end

  always_comb begin
    state_d    = state_q;
    o_d        = o_q;
    err_d      = err_q;
    xfer_cnt_d = xfer_cnt_q;
    ptr_d      = ptr_q;

    if (state_q == ST_EMPTY) begin
      if (load) state_d = ST_FULL;
    end else begin
      if (!load && OREADY) state_d = ST_EMPTY;
    end

    if (load) begin
      o_d        = sel_data;
      xfer_cnt_d = xfer_cnt_q + 1'b1;
      if (ARB == 1) begin
        ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
    end

    if ((ARB == 0) && sel_oob) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_EMPTY;
      o_q        <= '0;
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign IREADY   = ready;
  assign O        = o_q;
  assign OVALID   = (state_q == ST_FULL);
  assign ERR      = err_q;
  assign XFER_CNT = xfer_cnt_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench for pipe_mux_n: select mode (N=4), out-of-range select
// (N=3) and round-robin mode (N=4), scoreboard-checked output words.
module tb_pipe_mux_n;

  logic clk;
  logic rst_n;

  // u0: ARB=0, N=4
  logic [63:0] i0;
  logic [3:0]  iv0, ir0;
  logic [1:0]  s0;
  logic [15:0] o0, cnt0;
  logic        ov0, or0, err0;

  // u1: ARB=0, N=3
  logic [47:0] i1;
  logic [2:0]  iv1, ir1;
  logic [1:0]  s1;
  logic [15:0] o1, cnt1;
  logic        ov1, or1, err1;

  // u2: ARB=1, N=4
  logic [63:0] i2;
  logic [3:0]  iv2, ir2;
  logic [1:0]  s2;
  logic [15:0] o2, cnt2;
  logic        ov2, or2, err2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] sb0_q[$];
  logic [15:0] sb2_q[$];
  logic [15:0] exp_cnt0;

  pipe_mux_n #(.WIDTH(16), .N(4), .ARB(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .I(i0), .IVALID(iv0), .IREADY(ir0), .S(s0),
    .O(o0), .OVALID(ov0), .OREADY(or0), .ERR(err0), .XFER_CNT(cnt0)
  );

  pipe_mux_n #(.WIDTH(16), .N(3), .ARB(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .I(i1), .IVALID(iv1), .IREADY(ir1), .S(s1),
    .O(o1), .OVALID(ov1), .OREADY(or1), .ERR(err1), .XFER_CNT(cnt1)
  );

  pipe_mux_n #(.WIDTH(16), .N(4), .ARB(1)) u2 (
    .CLK(clk), .RST_N(rst_n), .I(i2), .IVALID(iv2), .IREADY(ir2), .S(s2),
    .O(o2), .OVALID(ov2), .OREADY(or2), .ERR(err2), .XFER_CNT(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pop_sb0();
    if (sb0_q.size() == 0) return 16'hxxxx;
    return sb0_q.pop_front();
  endfunction

  function automatic logic [15:0] pop_sb2();
    if (sb2_q.size() == 0) return 16'hxxxx;
    return sb2_q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    i0 = 64'h1111_2222_3333_4444; iv0 = 4'hF; s0 = 2'd0; or0 = 1'b1;
    i1 = '0; iv1 = 3'b000; s1 = 2'd0; or1 = 1'b1;
    i2 = '0; iv2 = 4'hF; s2 = 2'd0; or2 = 1'b1;
    exp_cnt0 = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (ir0 !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_iready0: got %b expected 0000", ir0); end
    tests_run++;
    if (ir2 !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_iready2: got %b expected 0000", ir2); end
    tests_run++;
    if (o0 !== 16'h0 || ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out: got O=%h OVALID=%b expected 0000/0", o0, ov0); end
    tests_run++;
    if (err0 !== 1'b0 || cnt0 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_err_cnt: got ERR=%b CNT=%h expected 0/0000", err0, cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    iv0 = 4'b0000; iv2 = 4'b0000;
  endtask

  task automatic test_select();
    logic [3:0]  exp_rdy;
    logic [15:0] exp;
    i0 = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    s0 = 2'd2; iv0 = 4'b0100; or0 = 1'b1;
    #1;
    tests_run++;
    if (ir0 !== 4'b0100) begin tests_failed++; $display("[TB] FAIL sel_beef_iready: got %b expected 0100", ir0); end
    sb0_q.push_back(16'hBEEF); exp_cnt0 = exp_cnt0 + 1'b1;
    @(negedge clk);
    exp = pop_sb0();
    tests_run++;
    if (ov0 !== 1'b1 || o0 !== exp || cnt0 !== exp_cnt0) begin
      tests_failed++; $display("[TB] FAIL sel_beef_out: got O=%h OV=%b CNT=%h expected %h/1/%h", o0, ov0, cnt0, exp, exp_cnt0);
    end
    // back-to-back sweep over every select value, distinct data per channel
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) i0[c*16 +: 16] = 16'hA000 + 16'(k*16 + c);
      s0 = 2'(k); iv0 = 4'b1111;
      exp_rdy = 4'b0001 << k;
      #1;
      tests_run++;
      if (ir0 !== exp_rdy) begin tests_failed++; $display("[TB] FAIL sweep_iready[%0d]: got %b expected %b", k, ir0, exp_rdy); end
      sb0_q.push_back(16'hA000 + 16'(k*17)); exp_cnt0 = exp_cnt0 + 1'b1;
      @(negedge clk);
      exp = pop_sb0();
      tests_run++;
      if (ov0 !== 1'b1 || o0 !== exp || cnt0 !== exp_cnt0) begin
        tests_failed++; $display("[TB] FAIL sweep_out[%0d]: got O=%h OV=%b CNT=%h expected %h/1/%h", k, o0, ov0, cnt0, exp, exp_cnt0);
      end
    end
    s0 = 2'd1; iv0 = 4'b1101;
    #1;
    tests_run++;
    if (ir0 !== 4'b0010) begin tests_failed++; $display("[TB] FAIL sel_invalid_iready: got %b expected 0010", ir0); end
    @(negedge clk);
    tests_run++;
    if (ov0 !== 1'b0 || cnt0 !== exp_cnt0) begin
      tests_failed++; $display("[TB] FAIL sel_invalid_drain: got OV=%b CNT=%h expected 0/%h", ov0, cnt0, exp_cnt0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    logic [15:0] held;
    i0 = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h1234};
    s0 = 2'd0; iv0 = 4'hF; or0 = 1'b1;
    sb0_q.push_back(16'h1234); exp_cnt0 = exp_cnt0 + 1'b1;
    @(negedge clk);
    exp = pop_sb0();
    held = exp;
    tests_run++;
    if (ov0 !== 1'b1 || o0 !== exp) begin tests_failed++; $display("[TB] FAIL bp_load: got O=%h OV=%b expected %h/1", o0, ov0, exp); end
    or0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i0 = {$urandom, $urandom};
      s0 = 2'(c); iv0 = 4'hF;
      #1;
      tests_run++;
      if (ir0 !== 4'b0000) begin tests_failed++; $display("[TB] FAIL bp_iready[%0d]: got %b expected 0000", c, ir0); end
      @(negedge clk);
      tests_run++;
      if (ov0 !== 1'b1 || o0 !== held || cnt0 !== exp_cnt0) begin
        tests_failed++; $display("[TB] FAIL bp_hold[%0d]: got O=%h OV=%b CNT=%h expected %h/1/%h", c, o0, ov0, cnt0, held, exp_cnt0);
      end
    end
    or0 = 1'b1; s0 = 2'd3; iv0 = 4'b1000;
    i0 = {16'h5678, 16'h0303, 16'h0202, 16'h0101};
    #1;
    tests_run++;
    if (ir0 !== 4'b1000) begin tests_failed++; $display("[TB] FAIL bp_release_iready: got %b expected 1000", ir0); end
    sb0_q.push_back(16'h5678); exp_cnt0 = exp_cnt0 + 1'b1;
    @(negedge clk);
    exp = pop_sb0();
    tests_run++;
    if (ov0 !== 1'b1 || o0 !== exp || cnt0 !== exp_cnt0) begin
      tests_failed++; $display("[TB] FAIL bp_release_out: got O=%h OV=%b CNT=%h expected %h/1/%h", o0, ov0, cnt0, exp, exp_cnt0);
    end
    iv0 = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (ov0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drain: got OV=%b expected 0", ov0); end
  endtask

  task automatic test_err();
    i1 = {16'h3333, 16'h2222, 16'h1111};
    s1 = 2'd3; iv1 = 3'b111; or1 = 1'b1;
    #1;
    tests_run++;
    if (ir1 !== 3'b000 || err1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_iready: got IREADY=%b ERR=%b expected 000/0", ir1, err1); end
    @(negedge clk);
    tests_run++;
    if (ov1 !== 1'b0 || err1 !== 1'b1 || cnt1 !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL err_set: got OV=%b ERR=%b CNT=%h expected 0/1/0000", ov1, err1, cnt1);
    end
    s1 = 2'd0; iv1 = 3'b000;
    @(negedge clk);
    tests_run++;
    if (err1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky: got %b expected 1", err1); end
    // park u1 FULL with ERR set for the asynchronous reset check
    s1 = 2'd1; i1 = {16'h3333, 16'hCAFE, 16'h1111}; iv1 = 3'b010; or1 = 1'b0;
    #1;
    tests_run++;
    if (ir1 !== 3'b010) begin tests_failed++; $display("[TB] FAIL err_recover_iready: got %b expected 010", ir1); end
    @(negedge clk);
    iv1 = 3'b000;
    tests_run++;
    if (ov1 !== 1'b1 || o1 !== 16'hCAFE || cnt1 !== 16'h1) begin
      tests_failed++; $display("[TB] FAIL err_recover_out: got O=%h OV=%b CNT=%h expected CAFE/1/0001", o1, ov1, cnt1);
    end
  endtask

  task automatic test_round_robin();
    int          exp_g[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    logic [3:0]  ivp[8]   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'hA};
    logic [3:0]  exp_rdy;
    logic [15:0] exp;
    i2 = {16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00};
    or2 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      iv2 = ivp[j];
      exp_rdy = 4'b0001 << exp_g[j];
      #1;
      tests_run++;
      if (ir2 !== exp_rdy) begin tests_failed++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", j, ir2, exp_rdy); end
      sb2_q.push_back(16'h0C00 + 16'(exp_g[j]));
      @(negedge clk);
      exp = pop_sb2();
      tests_run++;
      if (ov2 !== 1'b1 || o2 !== exp) begin tests_failed++; $display("[TB] FAIL rr_out[%0d]: got O=%h OV=%b expected %h/1", j, o2, ov2, exp); end
    end
    iv2 = 4'b0000;
    tests_run++;
    if (cnt2 !== 16'd8 || err2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_cnt: got CNT=%h ERR=%b expected 0008/0", cnt2, err2); end
  endtask

  task automatic test_wrap();
    int n;
    s0 = 2'd0; iv0 = 4'b0001; or0 = 1'b1;
    n = 16'hFFFE - int'(exp_cnt0);
    repeat (n) @(negedge clk);
    iv0 = 4'b0000;
    exp_cnt0 = exp_cnt0 + 16'(n);
    tests_run++;
    if (cnt0 !== exp_cnt0) begin tests_failed++; $display("[TB] FAIL wrap_fffe: got %h expected %h", cnt0, exp_cnt0); end
    iv0 = 4'b0001;
    @(negedge clk);
    iv0 = 4'b0000;
    exp_cnt0 = exp_cnt0 + 1'b1;
    tests_run++;
    if (cnt0 !== exp_cnt0) begin tests_failed++; $display("[TB] FAIL wrap_ffff: got %h expected %h", cnt0, exp_cnt0); end
    iv0 = 4'b0001;
    @(negedge clk);
    iv0 = 4'b0000;
    exp_cnt0 = exp_cnt0 + 1'b1;
    tests_run++;
    if (cnt0 !== exp_cnt0) begin tests_failed++; $display("[TB] FAIL wrap_zero: got %h expected %h", cnt0, exp_cnt0); end
    or0 = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    tests_run++;
    if (ov0 !== 1'b1 || ov1 !== 1'b1 || err1 !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL areset_pre: got OV0=%b OV1=%b ERR1=%b expected 1/1/1", ov0, ov1, err1);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (o0 !== 16'h0 || ov0 !== 1'b0 || cnt0 !== 16'h0 || ir0 !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL areset_u0: got O=%h OV=%b CNT=%h IREADY=%b expected 0000/0/0000/0000", o0, ov0, cnt0, ir0);
    end
    tests_run++;
    if (o1 !== 16'h0 || ov1 !== 1'b0 || err1 !== 1'b0 || cnt1 !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL areset_u1: got O=%h OV=%b ERR=%b CNT=%h expected 0000/0/0/0000", o1, ov1, err1, cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_err();
    test_round_robin();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 Parameter WIDTH, default 16: data width of every channel and of O.
REQ-002 Parameter N, default 4, legal 2..8: number of input channels.
REQ-003 Parameter ARB, default 0: 0 means select-driven (S chooses the channel); 1 means round-robin arbitration, with S ignored.
REQ-004 Localparam SW = max(1, clog2(N)): width of S and of the round-robin pointer.
REQ-005 CLK input, 1 bit: the single clock, rising-edge active.
REQ-006 RST_N input, 1 bit: reset, asynchronous and active-low.
REQ-007 I input, N*WIDTH bits: packed channel data; channel k occupies I[k*WIDTH +: WIDTH].
REQ-008 IVALID input, N bits: per-channel valid.
REQ-009 IREADY output, N bits: per-channel ready; at most one bit is high in any cycle.
REQ-010 S input, SW bits: channel select, used only when ARB=0.
REQ-011 O output, WIDTH bits: registered output data.
REQ-012 OVALID output, 1 bit: O holds a valid word.
REQ-013 OREADY input, 1 bit: downstream accepts O.
REQ-014 ERR output, 1 bit: sticky flag, set when S >= N while ARB=0.
REQ-015 XFER_CNT output, 16 bits: count of accepted input transfers, wrapping.

Function
REQ-016 The block has a single output register stage; a word is loaded into it when load_en = (!OVALID || OREADY) and the granted channel has IVALID=1.
REQ-017 Latency is one cycle: data accepted at edge t appears on O with OVALID=1 after edge t.
REQ-018 IREADY[g] equals load_en for the granted channel g, and every other IREADY bit is 0; IREADY is combinational from OVALID, OREADY, S (ARB=0), IVALID (ARB=1) and the pointer.
REQ-019 For ARB=0, the grant is g = S.
REQ-020 For ARB=0 with S >= N: no channel is granted, all IREADY bits are 0, nothing is loaded, and ERR is set at the next edge and held until reset.
REQ-021 For ARB=1, the grant is the first channel with IVALID=1, searching from the pointer PTR upward modulo N; if no channel is valid, there is no grant.
REQ-022 For ARB=1, after each accepted transfer from channel g, PTR becomes (g+1) mod N; otherwise PTR holds.
REQ-023 Output state machine EMPTY/FULL, where OVALID=1 exactly in FULL:
  - EMPTY to FULL on a load.
  - FULL to EMPTY when OREADY=1 and there is no load.
  - FULL stays FULL on simultaneous OREADY and load (back-to-back, full throughput).
  - FULL stays FULL holding O stable when OREADY=0.
REQ-024 O, once OVALID=1, does not change until the cycle after OREADY=1 is sampled.
REQ-025 XFER_CNT increments by 1 on every load; it wraps from 16'hFFFF to 0.
REQ-026 Changes on S or IVALID while the block is FULL with OREADY=0 have no effect on O.

Reset
REQ-027 While RST_N=0, all state clears asynchronously:
  - O = 0, OVALID = 0, ERR = 0, XFER_CNT = 0, PTR = 0, state = EMPTY.
REQ-028 During reset, IREADY = 0.
REQ-029 Reset asserted mid-transfer discards the held word; no transfer is counted.
REQ-030 The first load is possible at the first rising edge after RST_N deasserts.

Structure
REQ-031 A shared package datapath_pkg holds:
  - the EMPTY/FULL state encoding;
  - the default WIDTH (16);
  - the XFER_CNT width (16).
REQ-032 Grant selection is a sub-module rr_grant (inputs: request vector, pointer; outputs: grant index, grant valid); it is used when ARB=1 and bypassed when ARB=0.
REQ-033 No simulation-only constructs ($display) are used for range errors; ERR replaces them.

Verification
REQ-034 ARB=0, N=4, S=2, I[2]=16'hBEEF, IVALID=4'b0100, OREADY=1 gives:
  - IREADY = 4'b0100;
  - the next cycle O=16'hBEEF, OVALID=1, XFER_CNT=1.
REQ-035 ARB=0, N=3, S=3, IVALID=3'b111 gives:
  - IREADY = 0 and OVALID stays 0;
  - ERR=1 next cycle, still 1 after S returns to 0.
REQ-036 Backpressure: FULL with O=16'h1234 and OREADY=0 for 5 cycles while I changes gives:
  - O=16'h1234 held throughout and IREADY = 0;
  - then OREADY=1 gives a new word on the next cycle.
REQ-037 ARB=1, N=4, IVALID=4'b1111 held, OREADY=1 gives:
  - grants 0,1,2,3,0 on consecutive cycles;
  - with IVALID=4'b1010 instead, grants alternate 1,3,1.
REQ-038 XFER_CNT preset near wrap (16'hFFFE via 65534 transfers, or a forced value) plus 2 loads gives 16'hFFFF, then 16'h0000.
REQ-039 RST_N pulled low asynchronously (mid-cycle) while FULL with ERR=1 gives:
  - O=0, OVALID=0, ERR=0, XFER_CNT=0 immediately, without waiting for a clock edge.
